spi_master: RTL and testbench



---
 rtl/spi_master.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB
//                first. Takes bytes over a valid/ready stream from the SPI
//                register block. Drives chip-select, serial clock and data-out
//                towards the GPIO alternate function. Returns one received
//                byte, as a single-cycle pulse, for every byte sent.
//
//  Ports       :
//      clk       in   system clock
//      rst       in   synchronous, active-high reset
//      clkdiv    in   SCK half-period in clk cycles (0 behaves as 1)
//      cs_hold   in   keep spi_cs_n asserted while idle
//      tx_valid  in   tx_data is valid
//      tx_ready  out  byte accepted when tx_valid && tx_ready
//      tx_data   in   byte to transmit
//      rx_valid  out  one-cycle pulse, rx_data has just been updated
//      rx_data   out  last received byte (held between pulses)
//      busy      out  transfer FSM is not idle
//      spi_cs_n  out  chip select, active low (flop)
//      spi_sck   out  serial clock (flop)
//      spi_mosi  out  serial data out (flop)
//      spi_miso  in   serial data in, raw pad
//
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int W_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_DIV-1:0] clkdiv,
    input  logic             cs_hold,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             spi_cs_n,
    output logic             spi_sck,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    localparam logic [W_DIV-1:0] c_div_one = W_DIV'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           r_state;
    logic [W_DIV-1:0] r_half;      // latched half-period for the current byte
    logic [W_DIV-1:0] r_cnt;       // cycles left in the current phase, minus one
    logic [2:0]       r_bit;       // index of the bit currently on spi_mosi
    logic [6:0]       r_tx_sr;     // bits still to be driven after the current one
    logic [6:0]       r_rx_sr;     // first seven sampled bits of the byte
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_cs_n;
    logic             r_sck;
    logic             r_mosi;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [W_DIV-1:0] w_half_new;
    logic             w_phase_end;
    logic             w_ready;
    logic             w_accept;

    // A zero divider would give an empty phase; clamp it to one cycle.
    assign w_half_new  = (clkdiv == '0) ? c_div_one : clkdiv;
    assign w_phase_end = (r_cnt == '0);

    // The final TRAIL cycle doubles as the accept slot for a back-to-back
    // byte, so the next byte skips LEAD and goes straight to its first HIGH.
    assign w_ready  = !rst && ((r_state == ST_IDLE) ||
                               ((r_state == ST_TRAIL) && w_phase_end));
    assign w_accept = w_ready && tx_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_phase_end) begin
                    w_state_nxt = (r_bit == 3'd0) ? ST_TRAIL : ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_phase_end) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_TRAIL: begin
                if (w_phase_end) begin
                    w_state_nxt = w_accept ? ST_HIGH : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transfer FSM with registered pad outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_half     <= c_div_one;
            r_cnt      <= '0;
            r_bit      <= 3'd7;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_valid <= 1'b0;
            // Chip select follows where the FSM is heading. During a transfer
            // next state is never IDLE, so cs_hold only matters once idle.
            r_cs_n     <= !((w_state_nxt != ST_IDLE) || cs_hold);

            case (r_state)
                ST_IDLE: begin
                    r_sck <= 1'b0;
                    if (w_accept) begin
                        r_half  <= w_half_new;
                        r_cnt   <= w_half_new - c_div_one;
                        r_tx_sr <= tx_data[6:0];
                        r_mosi  <= tx_data[7];
                        r_bit   <= 3'd7;
                    end
                end

                ST_LEAD: begin
                    if (w_phase_end) begin
                        r_sck <= 1'b1;
                        r_cnt <= r_half - c_div_one;
                    end else begin
                        r_cnt <= r_cnt - c_div_one;
                    end
                end

                ST_HIGH: begin
                    if (w_phase_end) begin
                        // miso is sampled on the last HIGH cycle. This is the
                        // latest point before the falling edge. The slave has
                        // had the whole high phase to settle the pad.
                        r_rx_sr <= {r_rx_sr[5:0], spi_miso};
                        r_sck   <= 1'b0;
                        r_cnt   <= r_half - c_div_one;
                        if (r_bit == 3'd0) begin
                            r_rx_data  <= {r_rx_sr, spi_miso};
                            r_rx_valid <= 1'b1;
                        end else begin
                            // Present the next bit together with the falling edge.
                            r_mosi  <= r_tx_sr[6];
                            r_tx_sr <= {r_tx_sr[5:0], 1'b0};
                            r_bit   <= r_bit - 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_div_one;
                    end
                end

                ST_LOW: begin
                    if (w_phase_end) begin
                        r_sck <= 1'b1;
                        r_cnt <= r_half - c_div_one;
                    end else begin
                        r_cnt <= r_cnt - c_div_one;
                    end
                end

                ST_TRAIL: begin
                    if (w_phase_end) begin
                        if (w_accept) begin
                            // TRAIL has already served as this byte's lead-in.
                            r_half  <= w_half_new;
                            r_cnt   <= w_half_new - c_div_one;
                            r_tx_sr <= tx_data[6:0];
                            r_mosi  <= tx_data[7];
                            r_bit   <= 3'd7;
                            r_sck   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_div_one;
                    end
                end

                default: begin
                    r_sck <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_ready = w_ready;
    assign busy     = (r_state != ST_IDLE);
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign spi_cs_n = r_cs_n;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench for spi_master. Checks each waveform
//                against a per-cycle reference computed from the byte timing
//                rules (half-period H, 17H frame), plus protocol-level
//                monitors for chip-select runs, SCK edges and received bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] clkdiv;
    logic       cs_hold;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_cs_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_miso;

    logic       miso_loop;
    logic       miso_drv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign spi_miso = miso_loop ? spi_mosi : miso_drv;

    spi_master #(.W_DIV(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .clkdiv   (clkdiv),
        .cs_hold  (cs_hold),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    // ------------------------------------------------------------------------
    // Bus monitor: chip-select low runs, SCK rising edges, received bytes
    // ------------------------------------------------------------------------
    logic       r_prev_sck = 1'b0;
    int         r_cs_run   = 0;
    int         r_n_rise   = 0;
    int         cs_runs[$];
    logic       mosi_at_rise[$];
    logic [7:0] rx_seen[$];

    always @(negedge clk) begin
        if (spi_sck && !r_prev_sck) begin
            r_n_rise <= r_n_rise + 1;
            mosi_at_rise.push_back(spi_mosi);
        end
        r_prev_sck <= spi_sck;
        if (rx_valid) begin
            rx_seen.push_back(rx_data);
        end
        if (!spi_cs_n) begin
            r_cs_run <= r_cs_run + 1;
        end else if (r_cs_run > 0) begin
            cs_runs.push_back(r_cs_run);
            r_cs_run <= 0;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference frame for one isolated byte with half-period h, counted from
    // the first cycle after the accepting edge (k = 0). Returns
    // {busy, cs_n, sck, mosi, tx_ready, rx_valid}.
    function automatic logic [5:0] model_sig(input logic [7:0] b, input int h, input int k);
        logic busy_e, cs_e, sck_e, mosi_e, rdy_e, rxv_e;
        int   idx;
        busy_e = (k < 17 * h);
        cs_e   = !busy_e;
        sck_e  = (k >= h) && (k < 16 * h) && ((((k - h) / h) % 2) == 0);
        idx    = k / (2 * h);
        if (idx > 7) idx = 7;
        mosi_e = b[7 - idx];
        rdy_e  = (k >= 17 * h - 1);
        rxv_e  = (k == 16 * h);
        return {busy_e, cs_e, sck_e, mosi_e, rdy_e, rxv_e};
    endfunction

    // Present a byte and return just after the edge that accepts it.
    // tx_valid is left asserted for back-to-back streaming.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check_val("send_timeout", 32'(0), 32'(1));
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 5000) begin
            tick();
            i++;
        end
        if (busy) check_val("idle_timeout", 32'(1), 32'(0));
    endtask

    // Send one isolated byte (loopback, cs_hold=0) and compare every cycle of
    // the frame against the reference. Optionally changes clkdiv mid-byte.
    task automatic trace_check(input logic [7:0] b, input int h,
                               input bit mid_div, input logic [7:0] new_div);
        bit         ok;
        logic [5:0] got;
        logic [5:0] exp;
        send_byte(b, ok);
        tx_valid = 1'b0;
        if (ok) begin
            for (int k = 0; k < 17 * h + 2; k++) begin
                tick();
                if (mid_div && k == 1) clkdiv = new_div;
                exp = model_sig(b, h, k);
                got = {busy, spi_cs_n, spi_sck, spi_mosi, tx_ready, rx_valid};
                check_val($sformatf("trace b=%02h h=%0d k=%0d", b, h, k), 32'(got), 32'(exp));
                if (k == 16 * h) check_val($sformatf("trace_rx b=%02h", b), 32'(rx_data), 32'(b));
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int         base_runs;
        int         base_rise;
        int         base_rx;
        int         n_hi;
        int         i;
        int         h;
        bit         ok;
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] stream[3];

        rst       = 1'b1;
        clkdiv    = 8'd1;
        cs_hold   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        miso_loop = 1'b1;
        miso_drv  = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check_val("rst_cs_n",     32'(spi_cs_n), 32'(1));
        check_val("rst_sck",      32'(spi_sck),  32'(0));
        check_val("rst_mosi",     32'(spi_mosi), 32'(0));
        check_val("rst_rx_data",  32'(rx_data),  32'(0));
        check_val("rst_rx_valid", 32'(rx_valid), 32'(0));
        check_val("rst_tx_ready", 32'(tx_ready), 32'(0));
        check_val("rst_busy",     32'(busy),     32'(0));
        rst = 1'b0;
        tick();
        check_val("post_rst_ready", 32'(tx_ready), 32'(1));

        // ---- 0xA5, H=1, loopback ----
        base_runs = cs_runs.size();
        base_rise = r_n_rise;
        base_rx   = rx_seen.size();
        trace_check(8'hA5, 1, 1'b0, 8'd0);
        tick();
        check_val("a5_cs_runs", 32'(cs_runs.size() - base_runs), 32'(1));
        if (cs_runs.size() > base_runs) check_val("a5_cs_len", 32'(cs_runs[base_runs]), 32'(17));
        check_val("a5_rises", 32'(r_n_rise - base_rise), 32'(8));
        if (mosi_at_rise.size() >= base_rise + 8) begin
            b = 8'hA5;
            for (int k = 0; k < 8; k++)
                check_val($sformatf("a5_mosi_bit%0d", 7 - k), 32'(mosi_at_rise[base_rise + k]), 32'(b[7 - k]));
        end
        check_val("a5_rx_count", 32'(rx_seen.size() - base_rx), 32'(1));
        if (rx_seen.size() > base_rx) check_val("a5_rx_data", 32'(rx_seen[base_rx]), 32'(8'hA5));

        // ---- back-to-back 0x01,0x80,0xFF, H=2, miso tied high ----
        miso_loop = 1'b0;
        miso_drv  = 1'b1;
        clkdiv    = 8'd2;
        stream    = '{8'h01, 8'h80, 8'hFF};
        base_runs = cs_runs.size();
        base_rise = r_n_rise;
        base_rx   = rx_seen.size();
        for (int k = 0; k < 3; k++) send_byte(stream[k], ok);
        tx_valid = 1'b0;
        wait_idle();
        tick();
        tick();
        check_val("b2b_cs_runs", 32'(cs_runs.size() - base_runs), 32'(1));
        if (cs_runs.size() > base_runs) check_val("b2b_cs_len", 32'(cs_runs[base_runs]), 32'(98));
        check_val("b2b_rises", 32'(r_n_rise - base_rise), 32'(24));
        check_val("b2b_rx_count", 32'(rx_seen.size() - base_rx), 32'(3));
        for (int k = base_rx; k < rx_seen.size(); k++)
            check_val($sformatf("b2b_rx%0d", k - base_rx), 32'(rx_seen[k]), 32'(8'hFF));
        miso_loop = 1'b1;

        // ---- clkdiv 0 and 1 must both give the H=1 frame ----
        clkdiv = 8'd0;
        trace_check(8'h3C, 1, 1'b0, 8'd0);
        clkdiv = 8'd1;
        trace_check(8'h3C, 1, 1'b0, 8'd0);

        // ---- cs_hold across an idle gap ----
        cs_hold = 1'b1;
        tick();
        base_rx = rx_seen.size();
        send_byte(8'h12, ok);
        tx_valid = 1'b0;
        wait_idle();
        n_hi = 0;
        repeat (20) begin
            tick();
            if (spi_cs_n) n_hi++;
        end
        check_val("cshold_gap_cs_high", 32'(n_hi), 32'(0));
        send_byte(8'h34, ok);
        tx_valid = 1'b0;
        wait_idle();
        tick();
        check_val("cshold_idle_cs", 32'(spi_cs_n), 32'(0));
        check_val("cshold_rx_count", 32'(rx_seen.size() - base_rx), 32'(2));
        if (rx_seen.size() >= base_rx + 2) begin
            check_val("cshold_rx0", 32'(rx_seen[base_rx]),     32'(8'h12));
            check_val("cshold_rx1", 32'(rx_seen[base_rx + 1]), 32'(8'h34));
        end
        cs_hold = 1'b0;
        tick();
        check_val("cshold_release_cs", 32'(spi_cs_n), 32'(1));
        check_val("cshold_release_busy", 32'(busy), 32'(0));

        // ---- reset during the bit-4 HIGH phase ----
        clkdiv    = 8'd2;
        base_rise = r_n_rise;
        send_byte(8'hC3, ok);
        tx_valid = 1'b0;
        i = 0;
        while ((r_n_rise - base_rise) < 4 && i < 200) begin
            tick();
            i++;
        end
        check_val("abort_reach_bit4", 32'(r_n_rise - base_rise), 32'(4));
        check_val("abort_sck_high", 32'(spi_sck), 32'(1));
        base_rx = rx_seen.size();
        rst = 1'b1;
        tick();
        check_val("abort_cs_n",     32'(spi_cs_n), 32'(1));
        check_val("abort_sck",      32'(spi_sck),  32'(0));
        check_val("abort_ready_in_rst", 32'(tx_ready), 32'(0));
        check_val("abort_busy",     32'(busy),     32'(0));
        check_val("abort_rx_data",  32'(rx_data),  32'(0));
        rst = 1'b0;
        tick();
        check_val("abort_ready_after", 32'(tx_ready), 32'(1));
        repeat (4) tick();
        check_val("abort_no_rx", 32'(rx_seen.size() - base_rx), 32'(0));
        trace_check(8'h5A, 2, 1'b0, 8'd0);

        // ---- clkdiv change mid-byte takes effect at the next accept ----
        clkdiv = 8'd1;
        trace_check(8'h00, 1, 1'b1, 8'd4);
        trace_check(8'h96, 4, 1'b0, 8'd0);

        // ---- randomized bytes and dividers ----
        for (int n = 0; n < 8; n++) begin
            b      = 8'($urandom);
            d      = 8'($urandom_range(0, 5));
            clkdiv = d;
            h      = (d == 8'd0) ? 1 : int'(d);
            trace_check(b, h, 1'b0, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
